// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// Queue entries are sized by kDATA_W/kADDR_W; the top-level W/A parameters must match them.
package regfile_wb_sched_pkg;

  localparam int kDATA_W  = 8;
  localparam int kADDR_W  = 4;
  localparam int kIMM_REG = 3;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LOAD,
    WB_IMM,
    WB_ALU
  } wb_src_e;

  typedef struct packed {
    logic [kADDR_W-1:0] addr;
    logic [kDATA_W-1:0] data;
    logic               filled;
  } lq_entry_t;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Requester/register-file bundle for the write-back scheduler.
// Handshake: a request (LdIssue, ImmValid, AluValid) is taken on the Clk edge where its ready is
// high; the requester holds valid and payload stable until then. MemValid is a strobe with no ready.
interface regfile_wb_sched_if #(
  parameter int W = 8,
  parameter int A = 4
);
  logic              LdIssue;
  logic [A-1:0]      LdAddr;
  logic              LdReady;
  logic              MemValid;
  logic [W-1:0]      MemData;
  logic              ImmValid;
  logic [W-1:0]      ImmData;
  logic              ImmReady;
  logic              AluValid;
  logic [A-1:0]      AluAddr;
  logic [W-1:0]      AluData;
  logic              AluReady;
  logic              RfWriteEn;
  logic              RfOp;
  logic [A-1:0]      RfWaddr;
  logic [W-1:0]      RfDataIn;
  logic [2**A-1:0]   Busy;
  logic              ErrSticky;

  modport master (
    output LdIssue, LdAddr, MemValid, MemData, ImmValid, ImmData, AluValid, AluAddr, AluData,
    input  LdReady, ImmReady, AluReady, RfWriteEn, RfOp, RfWaddr, RfDataIn, Busy, ErrSticky
  );

  modport slave (
    input  LdIssue, LdAddr, MemValid, MemData, ImmValid, ImmData, AluValid, AluAddr, AluData,
    output LdReady, ImmReady, AluReady, RfWriteEn, RfOp, RfWaddr, RfDataIn, Busy, ErrSticky
  );
endinterface

// File: rtl/regfile_wb_sched_load_queue.sv
// In-order queue of outstanding loads: allocate at tail, fill in issue order, pop at head.
// Pending is a registered view, so an entry allocated this cycle shows up next cycle.
module wb_load_queue
  import regfile_wb_sched_pkg::*;
#(
  parameter int W  = kDATA_W,
  parameter int A  = kADDR_W,
  parameter int QD = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            issue,
  input  logic [A-1:0]    issue_addr,
  input  logic            ret_valid,
  input  logic [W-1:0]    ret_data,
  input  logic            pop,
  output logic            full,
  output logic            ret_err,
  output logic [2**A-1:0] pending,
  output logic            head_filled,
  output logic [A-1:0]    head_addr,
  output logic [W-1:0]    head_data
);

  localparam int PW = $clog2(QD);
  localparam int CW = PW + 1;

  lq_entry_t         ent [QD];
  logic [QD-1:0]     valid;
  logic [PW-1:0]     head, tail, fill;
  logic [CW-1:0]     count, unfilled;
  logic              ret_ok;

  // A return needs an entry that was already allocated before this edge and is still unfilled.
  assign ret_ok      = ret_valid && (unfilled != '0);
  assign ret_err     = ret_valid && (unfilled == '0);
  assign full        = (count == CW'(QD));
  assign head_filled = valid[head] && ent[head].filled;
  assign head_addr   = ent[head].addr;
  assign head_data   = ent[head].data;

  always_comb begin
    pending = '0;
    for (int i = 0; i < QD; i++) begin
      if (valid[i]) pending[ent[i].addr] = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      count    <= '0;
      unfilled <= '0;
      valid    <= '0;
      for (int i = 0; i < QD; i++) ent[i].filled <= 1'b0;
    end else begin
      if (issue) begin
        ent[tail].addr   <= issue_addr;
        ent[tail].filled <= 1'b0;
        valid[tail]      <= 1'b1;
        tail             <= tail + 1'b1;
      end
      if (ret_ok) begin
        ent[fill].data   <= ret_data;
        ent[fill].filled <= 1'b1;
        fill             <= fill + 1'b1;
      end
      if (pop) begin
        valid[head]      <= 1'b0;
        ent[head].filled <= 1'b0;
        head             <= head + 1'b1;
      end
      count    <= count + CW'(issue) - CW'(pop);
      unfilled <= unfilled + CW'(issue) - CW'(ret_ok);
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: fixed-priority arbitration (load > immediate > ALU) of the single
// register-file write port, one registered output stage, and the hazard Busy vector.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int W  = kDATA_W,
  parameter int A  = kADDR_W,
  parameter int QD = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  regfile_wb_sched_if.slave bus
);

  logic            full, ret_err, head_filled, ld_issue;
  logic [A-1:0]    head_addr;
  logic [W-1:0]    head_data;
  logic [2**A-1:0] pending, busy;
  wb_src_e         grant;

  logic            we_q, op_q, err_q;
  logic [A-1:0]    waddr_q;
  logic [W-1:0]    wdata_q;

  assign ld_issue = bus.LdIssue && !full && !Reset;

  wb_load_queue #(.W(W), .A(A), .QD(QD)) u_queue (
    .Clk        (Clk),
    .Reset      (Reset),
    .issue      (ld_issue),
    .issue_addr (bus.LdAddr),
    .ret_valid  (bus.MemValid),
    .ret_data   (bus.MemData),
    .pop        (grant == WB_LOAD),
    .full       (full),
    .ret_err    (ret_err),
    .pending    (pending),
    .head_filled(head_filled),
    .head_addr  (head_addr),
    .head_data  (head_data)
  );

  // Holding Imm/ALU off pending registers keeps an older load from overwriting a younger result.
  always_comb begin
    grant = WB_NONE;
    if (!Reset) begin
      if (head_filled)                              grant = WB_LOAD;
      else if (bus.ImmValid && !pending[kIMM_REG])  grant = WB_IMM;
      else if (bus.AluValid && !pending[bus.AluAddr]) grant = WB_ALU;
    end
  end

  always_comb begin
    busy = pending;
    if (we_q) busy[waddr_q] = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      we_q    <= 1'b0;
      op_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q <= (grant != WB_NONE);
      case (grant)
        WB_LOAD: begin
          op_q    <= 1'b0;
          waddr_q <= head_addr;
          wdata_q <= head_data;
        end
        WB_IMM: begin
          op_q    <= 1'b1;
          waddr_q <= A'(kIMM_REG);
          wdata_q <= bus.ImmData;
        end
        WB_ALU: begin
          op_q    <= 1'b0;
          waddr_q <= bus.AluAddr;
          wdata_q <= bus.AluData;
        end
        default: ;
      endcase
      if (ret_err) err_q <= 1'b1;
    end
  end

  assign bus.LdReady   = Reset || !full;
  assign bus.ImmReady  = (grant == WB_IMM);
  assign bus.AluReady  = (grant == WB_ALU);
  assign bus.RfWriteEn = we_q;
  assign bus.RfOp      = op_q;
  assign bus.RfWaddr   = waddr_q;
  assign bus.RfDataIn  = wdata_q;
  assign bus.Busy      = busy;
  assign bus.ErrSticky = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: queue-based reference model checked every cycle, an expected
// write queue filled by the directed tests, and literal spot checks.
module tb_regfile_wb_sched;

  localparam int W  = 8;
  localparam int A  = 4;
  localparam int QD = 2;
  localparam int NR = 2**A;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  regfile_wb_sched_if #(.W(W), .A(A)) bus ();

  regfile_wb_sched #(.W(W), .A(A), .QD(QD)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [A+W:0] exp_q[$];   // {op, addr, data} of each expected register-file write

  // Reference model: loads in flight as queues of addresses and of returned data.
  logic [A-1:0] m_addr[$];
  logic [W-1:0] m_data[$];
  logic         m_we, m_op, m_err;
  logic [A-1:0] m_waddr;
  logic [W-1:0] m_wdata;

  function automatic void check1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge Clk) begin : model
    logic [NR-1:0] pend, busy_e;
    int            grant;
    bit            ret_ok, can_issue;
    logic [A+W:0]  e;
    pend = '0;
    foreach (m_addr[i]) pend[m_addr[i]] = 1'b1;
    grant = 0;
    if (!Reset) begin
      if (m_data.size() > 0)                          grant = 1;
      else if (bus.ImmValid && !pend[3])              grant = 2;
      else if (bus.AluValid && !pend[bus.AluAddr])    grant = 3;
    end
    busy_e = pend;
    if (m_we) busy_e[m_waddr] = 1'b1;

    if (check_en) begin
      check1("ld_ready",  32'(bus.LdReady),   32'(Reset || (m_addr.size() < QD)));
      check1("imm_ready", 32'(bus.ImmReady),  32'(grant == 2));
      check1("alu_ready", 32'(bus.AluReady),  32'(grant == 3));
      check1("rf_we",     32'(bus.RfWriteEn), 32'(m_we));
      check1("rf_op",     32'(bus.RfOp),      32'(m_op));
      check1("rf_waddr",  32'(bus.RfWaddr),   32'(m_waddr));
      check1("rf_data",   32'(bus.RfDataIn),  32'(m_wdata));
      check1("busy",      32'(bus.Busy),      32'(busy_e));
      check1("err",       32'(bus.ErrSticky), 32'(m_err));
      if (bus.RfWriteEn === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_order: unexpected write op=%0d addr=%0d data=%0h", bus.RfOp, bus.RfWaddr, bus.RfDataIn);
        end else begin
          e = exp_q.pop_front();
          if ({bus.RfOp, bus.RfWaddr, bus.RfDataIn} !== e) begin
            errors++;
            $display("FAIL wb_order: got op/addr/data %0h expected %0h", {bus.RfOp, bus.RfWaddr, bus.RfDataIn}, e);
          end
        end
      end
    end

    if (Reset) begin
      m_addr.delete();
      m_data.delete();
      m_we = 0; m_op = 0; m_waddr = '0; m_wdata = '0; m_err = 0;
    end else begin
      ret_ok    = m_addr.size() > m_data.size();
      can_issue = bus.LdIssue && (m_addr.size() < QD);
      m_we = (grant != 0);
      case (grant)
        1: begin m_op = 0; m_waddr = m_addr.pop_front(); m_wdata = m_data.pop_front(); end
        2: begin m_op = 1; m_waddr = A'(3); m_wdata = bus.ImmData; end
        3: begin m_op = 0; m_waddr = bus.AluAddr; m_wdata = bus.AluData; end
        default: ;
      endcase
      if (bus.MemValid) begin
        if (ret_ok) m_data.push_back(bus.MemData);
        else        m_err = 1'b1;
      end
      if (can_issue) m_addr.push_back(bus.LdAddr);
    end
  end

  task automatic to_drive();
    @(posedge Clk); #1;
  endtask

  task automatic to_sample();
    @(negedge Clk); #1;
  endtask

  task automatic issue_load(input logic [A-1:0] addr);
    bit ok = 0;
    bus.LdIssue = 1'b1;
    bus.LdAddr  = addr;
    for (int n = 0; n < 20 && !ok; n++) begin
      to_sample();
      ok = bus.LdReady;
      to_drive();
    end
    bus.LdIssue = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ld_accept_timeout: got no LdReady expected one within 20 cycles");
    end
  endtask

  task automatic mem_return(input logic [W-1:0] d);
    bus.MemValid = 1'b1;
    bus.MemData  = d;
    to_drive();
    bus.MemValid = 1'b0;
  endtask

  task automatic wait_alu();
    bit ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      to_sample();
      ok = bus.AluReady;
      to_drive();
    end
    bus.AluValid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL alu_accept_timeout: got no AluReady expected one within 20 cycles");
    end
  endtask

  initial begin : timeout
    #200000;
    errors++;
    $display("FAIL global_timeout: got no finish expected one before 200000");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : main
    bit imm_done, alu_done;
    bus.LdIssue = 0; bus.LdAddr = '0; bus.MemValid = 0; bus.MemData = '0;
    bus.ImmValid = 0; bus.ImmData = '0; bus.AluValid = 0; bus.AluAddr = '0; bus.AluData = '0;
    Reset = 1'b1;
    repeat (2) to_drive();
    Reset = 1'b0;
    check_en = 1'b1;

    // Reset state
    to_sample();
    check1("rst_ld_ready", 32'(bus.LdReady), 32'd1);
    check1("rst_busy",     32'(bus.Busy), 32'd0);
    check1("rst_err",      32'(bus.ErrSticky), 32'd0);
    check1("rst_we",       32'(bus.RfWriteEn), 32'd0);
    to_drive();

    // ALU write r5 = 0x3C
    exp_q.push_back({1'b0, 4'd5, 8'h3C});
    bus.AluValid = 1; bus.AluAddr = 4'd5; bus.AluData = 8'h3C;
    to_sample();
    check1("alu_same_cycle_ready", 32'(bus.AluReady), 32'd1);
    to_drive();
    bus.AluValid = 0;
    to_sample();
    check1("alu_wb_we",    32'(bus.RfWriteEn), 32'd1);
    check1("alu_wb_addr",  32'(bus.RfWaddr), 32'd5);
    check1("alu_wb_data",  32'(bus.RfDataIn), 32'h3C);
    check1("alu_wb_op",    32'(bus.RfOp), 32'd0);
    to_drive();

    // RAW/WAW on r4: load returns 0xA5 first, ALU 0x11 afterwards
    exp_q.push_back({1'b0, 4'd4, 8'hA5});
    exp_q.push_back({1'b0, 4'd4, 8'h11});
    issue_load(4'd4);
    bus.AluValid = 1; bus.AluAddr = 4'd4; bus.AluData = 8'h11;
    to_sample();
    check1("busy_r4",       32'(bus.Busy[4]), 32'd1);
    check1("alu_blocked_r4", 32'(bus.AluReady), 32'd0);
    to_drive();
    to_drive();
    mem_return(8'hA5);
    wait_alu();
    repeat (3) to_drive();

    // Full queue, held issue, pointer wrap over 5 loads
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 4'(6 + i), 8'(i + 1)});
    issue_load(4'd6);
    issue_load(4'd7);
    to_sample();
    check1("queue_full_ld_ready", 32'(bus.LdReady), 32'd0);
    to_drive();
    for (int i = 0; i < 5; i++) begin
      mem_return(8'(i + 1));
      if (i + 2 < 5) issue_load(4'(8 + i));
    end
    repeat (4) to_drive();

    // Priority: filled load head beats Imm and ALU
    exp_q.push_back({1'b0, 4'd2, 8'h55});
    exp_q.push_back({1'b1, 4'd3, 8'h7F});
    exp_q.push_back({1'b0, 4'd9, 8'h99});
    issue_load(4'd2);
    mem_return(8'h55);
    bus.ImmValid = 1; bus.ImmData = 8'h7F;
    bus.AluValid = 1; bus.AluAddr = 4'd9; bus.AluData = 8'h99;
    imm_done = 0; alu_done = 0;
    for (int k = 0; k < 10 && !(imm_done && alu_done); k++) begin
      to_sample();
      if (k == 0) check1("load_wins", 32'({bus.ImmReady, bus.AluReady}), 32'd0);
      if (k == 1) check1("imm_second", 32'({bus.ImmReady, bus.AluReady}), 32'b10);
      if (k == 2) check1("alu_third",  32'({bus.ImmReady, bus.AluReady}), 32'b01);
      if (bus.ImmReady) imm_done = 1;
      if (bus.AluReady) alu_done = 1;
      to_drive();
      if (imm_done) bus.ImmValid = 0;
      if (alu_done) bus.AluValid = 0;
    end
    bus.ImmValid = 0; bus.AluValid = 0;
    repeat (3) to_drive();

    // Stray return with empty queue
    mem_return(8'h42);
    to_sample();
    check1("stray_err", 32'(bus.ErrSticky), 32'd1);
    check1("stray_no_we", 32'(bus.RfWriteEn), 32'd0);
    to_drive();
    Reset = 1'b1;
    to_drive();
    Reset = 1'b0;
    to_sample();
    check1("reset_clears_err", 32'(bus.ErrSticky), 32'd0);
    to_drive();

    // Reset with a load outstanding, then a late return
    issue_load(4'd12);
    to_sample();
    check1("busy_r12", 32'(bus.Busy[12]), 32'd1);
    to_drive();
    Reset = 1'b1;
    to_drive();
    Reset = 1'b0;
    to_sample();
    check1("mid_reset_busy", 32'(bus.Busy), 32'd0);
    check1("mid_reset_ld_ready", 32'(bus.LdReady), 32'd1);
    to_drive();
    mem_return(8'h77);
    to_sample();
    check1("late_return_err", 32'(bus.ErrSticky), 32'd1);
    to_drive();
    repeat (3) to_drive();

    check1("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
